// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle of load_store_unit.
// master = execute-side producer/consumer, slave = the LSU itself.
interface load_store_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [4:0]        req_rd;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic [4:0]        rsp_rd;
   logic              rsp_misalign;
   logic              rsp_illegal;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_misalign, rsp_illegal
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_misalign, rsp_illegal
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a 1-cycle registered-read data memory.
// Optional LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of forcing alignment.
//
// state   | meaning
// IDLE    | ready for a request; latch it on req_valid
// MEM     | drive the memory access for one cycle
// WAIT    | capture and extend the returned load word
// RESP    | hold the response until rsp_ready
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   load_store_unit_if.slave  bus,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   output logic [3:0]        mem_be,
   input  logic [31:0]       mem_rdata
);

   generate
      if (DATA_W != 32) begin : g_bad_data_w
         $error("load_store_unit: DATA_W must be 32");
      end
   endgenerate

   typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_WAIT, ST_RESP} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic [4:0]        r_rd;
   logic              r_misalign;
   logic              r_illegal;

   logic              w_is_half;
   logic              w_is_word;
   logic              w_legal;
   logic              w_unaligned;
   logic              w_misalign;
   logic [ADDR_W-1:0] w_addr_eff;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load_val;

   always_comb begin
      w_is_half   = (bus.req_funct3[1:0] == 2'b01);
      w_is_word   = (bus.req_funct3[1:0] == 2'b10);
      w_unaligned = (w_is_half && bus.req_addr[0]) ||
                    (w_is_word && (bus.req_addr[1:0] != 2'b00));
      case (bus.req_funct3)
         3'b000, 3'b001, 3'b010: w_legal = 1'b1;
         3'b100, 3'b101:         w_legal = !bus.req_we;
         default:                w_legal = 1'b0;
      endcase
      w_addr_eff = bus.req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
      w_misalign = w_legal && w_unaligned;
`else
      w_misalign = 1'b0;
      // Drop the low address bits so the access proceeds as aligned.
      if (w_unaligned) begin
         w_addr_eff[1:0] = w_is_word ? 2'b00 : {bus.req_addr[1], 1'b0};
      end
`endif
   end

   always_comb begin
      case (r_addr[1:0])
         2'b00:   w_byte = mem_rdata[7:0];
         2'b01:   w_byte = mem_rdata[15:8];
         2'b10:   w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (r_funct3)
         3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_val = {24'h0, w_byte};
         3'b101:  w_load_val = {16'h0, w_half};
         default: w_load_val = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      mem_addr      = '0;
      mem_wdata     = 32'h0;
      mem_we        = 1'b0;
      mem_re        = 1'b0;
      mem_be        = 4'b0000;
      case (r_state)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               w_state_nxt = (!w_legal || w_misalign) ? ST_RESP : ST_MEM;
            end
         end
         ST_MEM: begin
            mem_addr    = r_addr;
            mem_we      = r_we;
            mem_re      = !r_we;
            mem_be      = 4'b1111;
            w_state_nxt = r_we ? ST_RESP : ST_WAIT;
            if (r_we) begin
               case (r_funct3[1:0])
                  2'b00: begin
                     mem_be    = 4'b0001 << r_addr[1:0];
                     mem_wdata = {4{r_wdata[7:0]}};
                  end
                  2'b01: begin
                     mem_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                     mem_wdata = {2{r_wdata[15:0]}};
                  end
                  default: mem_wdata = r_wdata;
               endcase
            end
         end
         ST_WAIT: w_state_nxt = ST_RESP;
         ST_RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we       <= 1'b0;
         r_funct3   <= 3'b000;
         r_addr     <= '0;
         r_wdata    <= 32'h0;
         r_rdata    <= 32'h0;
         r_rd       <= 5'd0;
         r_misalign <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (r_state == ST_IDLE && bus.req_valid) begin
         r_we       <= bus.req_we;
         r_funct3   <= bus.req_funct3;
         r_addr     <= w_addr_eff;
         r_wdata    <= bus.req_wdata;
         r_rd       <= bus.req_rd;
         r_misalign <= w_misalign;
         r_illegal  <= !w_legal;
         r_rdata    <= 32'h0;
      end else if (r_state == ST_WAIT) begin
         r_rdata    <= w_load_val;
      end
   end

   assign bus.rsp_rdata    = r_rdata;
   assign bus.rsp_rd       = r_rd;
   assign bus.rsp_misalign = r_misalign;
   assign bus.rsp_illegal  = r_illegal;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage between execute and the data memory. Accepts one load/store request at a time over a valid/ready handshake. Generates the byte enables and the lane-replicated write data for stores. Issues the access to the data memory, which has a 1-cycle registered read. Captures the returned word, then extracts and sign- or zero-extends the byte, half-word or word. Also flags misaligned and illegal accesses.

Parameters:
ADDR_W, 32, byte-address width of req_addr and mem_addr
DATA_W, 32, data width; fixed at 32, with any other value rejected at elaboration

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned
req_rd  input  5  destination register tag, returned unchanged
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  extended load result; 0 for stores and faults
rsp_rd  output  5  tag of the completed request
rsp_misalign  output  1  access was misaligned; no memory access made
rsp_illegal  output  1  funct3 invalid for the direction; no memory access made
mem_addr  output  ADDR_W  byte address to data memory
mem_wdata  output  32  lane-replicated store data
mem_we  output  1  write enable
mem_re  output  1  read enable
mem_be  output  4  byte enable, LSB = byte 0
mem_rdata  input  32  full word from data memory, valid the cycle after mem_re

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0 except req_ready = 1. A store in flight during its MEM cycle is abandoned; mem_we drops immediately.
- FSM states: IDLE, MEM, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, register we, funct3, addr, wdata and rd.
  - Legal and aligned -> MEM.
  - Fault -> RESP with the fault flag set, and no mem_we/mem_re pulse.
- MEM: drive mem_* from the registered fields for exactly 1 cycle. Store -> RESP. Load -> WAIT.
- WAIT: register the extracted value of mem_rdata into rsp_rdata, then -> RESP.
- RESP: rsp_valid = 1, with rsp_* held stable until rsp_ready. rsp_valid && rsp_ready -> IDLE. No new request is accepted in the same cycle.
- Latency from the accept edge to rsp_valid high: load 3 cycles, store 2 cycles, fault 1 cycle. Throughput is 1 request per at least 3 (load) or 2 (store) cycles plus the handshake.
- Legality:
  - Loads accept 000, 001, 010, 100, 101.
  - Stores accept 000, 001, 010.
  - Any other code sets rsp_illegal. Illegal takes priority over misalign.
- Alignment: H/HU need addr[0] = 0; W needs addr[1:0] = 00.
- Store encoding:
  - SB: mem_be = 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 1111; mem_wdata = wdata.
- Loads drive mem_be = 1111 and mem_wdata = 0.
- Load extraction from w = mem_rdata:
  - Byte b = w[8*addr[1:0] +: 8].
  - Half h = addr[1] ? w[31:16] : w[15:0].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes w unchanged.
- mem_addr is the full registered byte address, since the memory indexes by addr[31:2]. mem_we and mem_re are never high together, and are 0 outside MEM.
- A request arriving while req_ready = 0 is not sampled; the producer holds it.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misaligned accesses are faulted as above (rsp_misalign = 1, no memory access, rsp_rdata = 0).
- Undefined: misalignment is never flagged and rsp_misalign is tied 0.
  - H/HU/SH clear addr[0]; W/SW clear addr[1:0].
  - The access then proceeds as aligned, and mem_addr carries the forced address.

Test Plan:
- SB wdata = 0x000000A5 to addr 0x00000006 -> MEM cycle has mem_be = 0100, mem_wdata = 0xA5A5A5A5, mem_we = 1; rsp_valid 2 cycles after accept, rsp_rdata = 0.
- LB from addr 0x00000007 with mem_rdata = 0x80FF1234 -> rsp_rdata = 0xFFFFFF80; LBU from the same address -> 0x00000080; rsp_valid 3 cycles after accept.
- LH from addr 0x00000002 with mem_rdata = 0x8001BEEF -> 0xFFFF8001; LW from addr 0x00000000 with mem_rdata = 0xDEADBEEF -> 0xDEADBEEF.
- LW from addr 0x00000002:
  - With LSU_MISALIGN_TRAP_EN: rsp_misalign = 1 one cycle after accept, no mem_re pulse.
  - Without it: mem_addr = 0x00000000, normal load.
- Store with funct3 = 100 -> rsp_illegal = 1, no mem_we. Hold rsp_ready = 0 for 4 cycles -> rsp_* stable and req_ready = 0 throughout.
- Assert rst during the MEM cycle of an SW -> mem_we drops the same cycle, outputs return to reset values, and the next request completes normally.
